// File: rtl/bus_pkg.sv
// Shared definitions for the MMIO bus decoder slice.
//   bus_state_t  : transfer FSM states (IDLE / ACCESS / DONE)
//   RESP_*       : coded transfer responses returned with ready
//   idx_width()  : bit width needed to index n slaves (never below 1)
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } bus_state_t;

  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_MISALIGN = 2'b01;
  localparam logic [1:0] RESP_DECERR   = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT  = 2'b11;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state watchdog for one bus access.
// Counts enabled cycles from a clear; expired is a registered flag that is
// high on the cycle the count equals TIMEOUT.
//   clk, reset (async, active-low)
//   clear   : restart count at 0 and drop expired (has priority over en)
//   en      : count this cycle
//   expired : count == TIMEOUT (registered)
module bus_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;

  assign count_inc = count + 1'b1;

  // expired is computed from the next count so it lines up with the
  // cycle where count itself equals TIMEOUT; counting stops once set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (en && !expired) begin
      count   <= count_inc;
      expired <= (count_inc == CW'(TIMEOUT));
    end
  end

endmodule

// File: rtl/mmio_bus_decoder.sv
// Memory-mapped bus decoder between the MEM stage and NUM_SLAVES targets.
// The region field addr[SEL_LO+SEL_W-1:SEL_LO] picks a slave; each transfer
// is a req/ready handshake with per-slave wait states, a timeout watchdog
// and a coded response.
//   clk, reset (async, active-low)
//   req/we/addr/wdata/be : CPU request, held until ready
//   ready/resp/rdata     : one-cycle completion pulse with response and data
//   s_sel                : one-hot slave select, high for the ACCESS phase
//   s_we/s_addr/s_wdata/s_be : registered copies of the CPU fields
//   s_rdata/s_ready      : flattened slave read data and per-slave ready
module mmio_bus_decoder
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEL_LO     = 7,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          be,
  output logic                         ready,
  output logic [1:0]                   resp,
  output logic [DATA_W-1:0]            rdata,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_be,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

  bus_state_t        state;
  logic [IDX_W-1:0]  slv_idx;
  logic [SEL_W-1:0]  region;
  logic [IDX_W-1:0]  region_idx;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_expired;

  assign region     = addr[SEL_LO+SEL_W-1:SEL_LO];
  assign region_idx = IDX_W'(region);

  // Only the latched target's ready/data are ever looked at.
  always_comb begin
    sel_ready = s_ready[slv_idx];
    sel_rdata = s_rdata[32'(slv_idx) * DATA_W +: DATA_W];
  end

  assign tmr_clear = (state != ACCESS);
  assign tmr_en    = (state == ACCESS) && !sel_ready;

  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ready   <= 1'b0;
      resp    <= RESP_OK;
      rdata   <= '0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_be    <= '0;
      slv_idx <= '0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            s_we    <= we;
            s_addr  <= addr;
            s_wdata <= wdata;
            s_be    <= be;
            // Misalignment is checked before the region so an unaligned
            // access to a missing slave reports MISALIGN.
            if (addr[1:0] != 2'b00) begin
              resp  <= RESP_MISALIGN;
              rdata <= '0;
              ready <= 1'b1;
              state <= DONE;
            end else if (32'(region) >= NUM_SLAVES) begin
              resp  <= RESP_DECERR;
              rdata <= '0;
              ready <= 1'b1;
              state <= DONE;
            end else begin
              slv_idx             <= region_idx;
              s_sel               <= '0;
              s_sel[region_idx]   <= 1'b1;
              state               <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // A ready arriving on the expiry cycle still completes normally.
          if (sel_ready) begin
            resp  <= RESP_OK;
            rdata <= s_we ? '0 : sel_rdata;
            s_sel <= '0;
            ready <= 1'b1;
            state <= DONE;
          end else if (tmr_expired) begin
            resp  <= RESP_TIMEOUT;
            rdata <= '0;
            s_sel <= '0;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          s_sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
module tb_mmio_bus_decoder;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             we;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic [DW/8-1:0]  be;
  logic             ready;
  logic [1:0]       resp;
  logic [DW-1:0]    rdata;
  logic [NS-1:0]    s_sel;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW/8-1:0]  s_be;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ready;

  mmio_bus_decoder #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SEL_LO     (7),
    .SEL_W      (2),
    .TIMEOUT    (15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .ready   (ready),
    .resp    (resp),
    .rdata   (rdata),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_be    (s_be),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        chk_rd;
    int          lat;
    int          selcnt;
  } exp_t;

  exp_t sbq[$];

  // tgt: slave expected to be selected (-1 none); delay: wait cycles before
  // that slave raises ready (-1 never); stray: another slave holding ready high.
  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          tgt;
    int          delay;
    int          stray;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        chk_rd;
    int          lat;
    int          selcnt;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t          e;
    logic [NS-1:0] oh;
    int            c;
    int            selseen;
    int            selhi;
    int            badsel;
    bit            got;
    oh = '0;
    if (v.tgt >= 0) oh[v.tgt] = 1'b1;
    e.resp   = v.resp;
    e.rdata  = v.rdata;
    e.chk_rd = v.chk_rd;
    e.lat    = v.lat;
    e.selcnt = v.selcnt;
    sbq.push_back(e);

    req     = 1'b1;
    we      = v.we;
    addr    = v.addr;
    wdata   = v.wdata;
    be      = v.be;
    s_ready = '0;
    @(posedge clk); #1;
    c = 1; selseen = 0; selhi = 0; badsel = 0; got = 1'b0;
    check({v.name, "_s_we"},    32'(s_we),  32'(v.we));
    check({v.name, "_s_addr"},  s_addr,     v.addr);
    check({v.name, "_s_wdata"}, s_wdata,    v.wdata);
    check({v.name, "_s_be"},    32'(s_be),  32'(v.be));
    while (c <= 40) begin
      s_ready = '0;
      if (ready) begin
        got = 1'b1;
        break;
      end
      if (s_sel != '0) selhi++;
      if (s_sel !== oh && s_sel !== '0) badsel++;
      if (v.tgt >= 0 && s_sel == oh) begin
        if (selseen == v.delay) s_ready[v.tgt] = 1'b1;
        selseen++;
      end
      if (v.stray >= 0) s_ready[v.stray] = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    s_ready = '0;
    req     = 1'b0;
    e = sbq.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_ready: no completion within 40 cycles, expected latency %0d", v.name, e.lat);
    end else begin
      check({v.name, "_resp"}, 32'(resp), 32'(e.resp));
      if (e.chk_rd) check({v.name, "_rdata"}, rdata, e.rdata);
      check({v.name, "_latency"}, 32'(c), 32'(e.lat));
    end
    check({v.name, "_sel_cycles"}, 32'(selhi), 32'(e.selcnt));
    check({v.name, "_bad_sel"}, 32'(badsel), 32'd0);
    // Back in IDLE: pulse gone, response and data held.
    @(posedge clk); #1;
    check({v.name, "_ready_pulse"}, 32'(ready), 32'd0);
    check({v.name, "_resp_hold"}, 32'(resp), 32'(e.resp));
    if (e.chk_rd) check({v.name, "_rdata_hold"}, rdata, e.rdata);
  endtask

  initial begin
    tbl[0]  = '{name:"rd_s0",     we:1'b0, addr:32'h0000_0040, wdata:32'h0,         be:4'hF, tgt:0,  delay:0,  stray:-1,
                resp:2'b00, rdata:32'h1234_5678, chk_rd:1'b1, lat:2,  selcnt:1};
    tbl[1]  = '{name:"wr_s1",     we:1'b1, addr:32'h0000_0084, wdata:32'hCAFE_0001, be:4'h3, tgt:1,  delay:3,  stray:-1,
                resp:2'b00, rdata:32'h0,         chk_rd:1'b1, lat:5,  selcnt:4};
    tbl[2]  = '{name:"decerr",    we:1'b0, addr:32'h0000_0180, wdata:32'h0,         be:4'hF, tgt:-1, delay:-1, stray:-1,
                resp:2'b10, rdata:32'h0,         chk_rd:1'b0, lat:1,  selcnt:0};
    tbl[3]  = '{name:"misalign",  we:1'b0, addr:32'h0000_0002, wdata:32'h0,         be:4'hF, tgt:-1, delay:-1, stray:-1,
                resp:2'b01, rdata:32'h0,         chk_rd:1'b0, lat:1,  selcnt:0};
    tbl[4]  = '{name:"tmo_s2",    we:1'b0, addr:32'h0000_0100, wdata:32'h0,         be:4'hF, tgt:2,  delay:-1, stray:-1,
                resp:2'b11, rdata:32'h0,         chk_rd:1'b1, lat:17, selcnt:16};
    tbl[5]  = '{name:"edge_s2",   we:1'b0, addr:32'h0000_0100, wdata:32'h0,         be:4'hF, tgt:2,  delay:15, stray:-1,
                resp:2'b00, rdata:32'h0BAD_F00D, chk_rd:1'b1, lat:17, selcnt:16};
    tbl[6]  = '{name:"stray_s0",  we:1'b0, addr:32'h0000_0040, wdata:32'h0,         be:4'hF, tgt:0,  delay:2,  stray:1,
                resp:2'b00, rdata:32'h1234_5678, chk_rd:1'b1, lat:4,  selcnt:3};
    tbl[7]  = '{name:"rd_s1",     we:1'b0, addr:32'h0000_0084, wdata:32'h0,         be:4'hF, tgt:1,  delay:1,  stray:-1,
                resp:2'b00, rdata:32'hA5A5_0001, chk_rd:1'b1, lat:3,  selcnt:2};
    tbl[8]  = '{name:"wr_s0",     we:1'b1, addr:32'h0000_0000, wdata:32'h1122_3344, be:4'h8, tgt:0,  delay:14, stray:-1,
                resp:2'b00, rdata:32'h0,         chk_rd:1'b1, lat:16, selcnt:15};
    tbl[9]  = '{name:"wr_mis",    we:1'b1, addr:32'h0000_0103, wdata:32'hDEAD_BEEF, be:4'hF, tgt:-1, delay:-1, stray:-1,
                resp:2'b01, rdata:32'h0,         chk_rd:1'b0, lat:1,  selcnt:0};
    tbl[10] = '{name:"wr_dec",    we:1'b1, addr:32'h0000_01FC, wdata:32'h5555_AAAA, be:4'hF, tgt:-1, delay:-1, stray:-1,
                resp:2'b10, rdata:32'h0,         chk_rd:1'b0, lat:1,  selcnt:0};
    tbl[11] = '{name:"tmo_stray", we:1'b0, addr:32'h0000_0100, wdata:32'h0,         be:4'hF, tgt:2,  delay:-1, stray:0,
                resp:2'b11, rdata:32'h0,         chk_rd:1'b1, lat:17, selcnt:16};

    s_rdata = {32'h0BAD_F00D, 32'hA5A5_0001, 32'h1234_5678};
    s_ready = '0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    be      = '0;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   32'(ready),   32'd0);
    check("rst_resp",    32'(resp),    32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_s_sel",   32'(s_sel),   32'd0);
    check("rst_s_we",    32'(s_we),    32'd0);
    check("rst_s_addr",  s_addr,       32'd0);
    check("rst_s_wdata", s_wdata,      32'd0);
    check("rst_s_be",    32'(s_be),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset in the middle of an access to slave 0.
    req  = 1'b1;
    we   = 1'b0;
    addr = 32'h0000_0040;
    @(posedge clk); #1;
    check("mid_sel_before", 32'(s_sel), 32'b001);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("mid_sel_async",   32'(s_sel), 32'd0);
    check("mid_ready_async", 32'(ready), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    check("mid_ready_held", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    run_vec(tbl[0]);
    run_vec(tbl[6]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
